key_schedule: RTL and testbench
===============================

KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to begin expanding cipher_key.
REQ-004 SHALL have port cipher_key, input, [0:3][31:0]: AES-128 key, word 0 = most significant.
REQ-005 SHALL have port key_ready, input, 1 bit: downstream round stage accepts the current round_key.
REQ-006 SHALL have port round_key, output, [0:3][31:0]: current round key, formatted to drive the round stage's round_key input directly.
REQ-007 SHALL have port round_num, output, 4 bits: index 0..10 of round_key.
REQ-008 SHALL have port key_valid, output, 1 bit: round_key/round_num valid.
REQ-009 SHALL have port busy, output, 1 bit: high in EXPAND.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse after round 10 key is accepted.
REQ-011 SHALL have ports rd_idx, input, 4 bits, and rd_key, output, [0:3][31:0], for stored-key readback (see Configuration).

Function
REQ-012 SHALL implement the FSM states IDLE and EXPAND.
- IDLE -> EXPAND on start; no other IDLE exit.
- EXPAND -> IDLE on handshake with round_num == 10.
REQ-013 SHALL sample cipher_key when start=1 in IDLE; at the next edge round_key=cipher_key, round_num=0, key_valid=1.
REQ-014 SHALL define a handshake as key_valid & key_ready on a rising edge; only a handshake advances the schedule.
REQ-015 SHALL, on a handshake with round_num=r<10, present round key r+1 with round_num=r+1 at the same edge (one key per cycle when key_ready is held high).
REQ-016 SHALL hold round_key, round_num and key_valid stable while key_valid=1 and key_ready=0.
REQ-017 SHALL compute each next key per FIPS-197:
- temp = SubWord(RotWord(w3)) ^ Rcon[r+1].
- w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-018 SHALL use the Rcon byte sequence 01,02,04,08,10,20,40,80,1B,36 in the top byte, lower bytes zero.
REQ-019 SHALL implement SubWord with four combinational AES S-box lookups; no registers inside the next-key path.
REQ-020 SHALL, on a handshake at round_num=10, clear key_valid and busy, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-021 SHALL ignore start while in EXPAND; cipher_key changes during EXPAND SHALL have no effect.
REQ-022 SHALL accept start in the cycle done=1; expansion of the new key then begins without an idle gap.
REQ-023 SHALL drive busy=1 exactly while in EXPAND; key_valid SHALL equal busy.

Reset
REQ-024 SHALL, on rst=1 at any time including mid-expansion, immediately enter IDLE and drive round_key=0, round_num=0, key_valid=0, busy=0, done=0, rd_key=0.
REQ-025 SHALL, on rst=1, clear all internal key and Rcon registers and any stored keys to 0.
REQ-026 SHALL ignore start while rst=1; the first start after rst falls SHALL be honoured normally.

Configuration
REQ-027 SHALL, when KEY_STORE_EN is defined, store every round key 0..10 into an 11-entry register file as it is presented.
REQ-028 SHALL, when KEY_STORE_EN is defined, drive rd_key as entry rd_idx registered one cycle after rd_idx, and drive rd_key=0 for rd_idx>10.
REQ-029 SHALL, when KEY_STORE_EN is defined, overwrite entries only from a new start, so entries persist after done until the next start or reset.
REQ-030 SHALL, when KEY_STORE_EN is undefined, contain no key storage, tie rd_key to 0, and ignore rd_idx; all other behaviour is unchanged.

Verification
REQ-031 SHALL verify full-rate expansion: cipher_key=2b7e1516 28aed2a6 abf71588 09cf4f3c, key_ready held 1, start pulse -> round 1 = a0fafe17 88542cb1 23a33939 2a6c7605, round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, done exactly 11 cycles after the first key_valid cycle.
REQ-032 SHALL verify backpressure: same key with key_ready=0 for 3 cycles at round_num=4 -> round_key/round_num stable across the stall; final keys match REQ-031.
REQ-033 SHALL verify reset mid-operation: rst asserted at round_num=6 -> all outputs 0 in the same cycle; a new start after release yields round 0 = new cipher_key.
REQ-034 SHALL verify start handling: start pulsed during EXPAND -> ignored, sequence unchanged; start in the done cycle -> key_valid=1 with round_num=0 on the next edge.
REQ-035 SHALL verify KEY_STORE_EN: after REQ-031, rd_idx=10 -> rd_key=d014f9a8 c9ee2589 e13f0cc8 b6630ca6 one cycle later; rd_idx=12 -> 0; with macro undefined, rd_key=0 always.

Source files
------------

// File: rtl/key_schedule_if.sv
// Bus between the AES-128 key schedule and its requester / round stage.
interface key_schedule_if;
    logic              start;
    logic [0:3][31:0]  cipher_key;
    logic              key_ready;
    logic [0:3][31:0]  round_key;
    logic [3:0]        round_num;
    logic              key_valid;
    logic              busy;
    logic              done;
    logic [3:0]        rd_idx;
    logic [0:3][31:0]  rd_key;

    modport master (
        output start, cipher_key, key_ready, rd_idx,
        input  round_key, round_num, key_valid, busy, done, rd_key
    );

    modport slave (
        input  start, cipher_key, key_ready, rd_idx,
        output round_key, round_num, key_valid, busy, done, rd_key
    );
endinterface

// File: rtl/key_schedule.sv
// AES-128 key schedule: expands cipher_key into round keys 0..10, one per
// accepted handshake, with a purely combinational next-key path.
// Optional macro KEY_STORE_EN adds an 11-entry round-key store with
// registered readback on rd_idx/rd_key.
module key_schedule (
    input  logic          clk,
    input  logic          rst,
    key_schedule_if.slave bus
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 4;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8); steps Rcon 01..80 -> 1B -> 36.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t              r_state;
    logic [0:3][31:0]    r_key;
    logic [ROUND_W-1:0]  r_round;
    logic [7:0]          r_rcon;
    logic                r_done;

    logic [WORD_W-1:0]   w_rot;
    logic [WORD_W-1:0]   w_temp;
    logic [0:3][31:0]    w_next;
    logic                w_hs;

    assign w_hs = (r_state == EXPAND) && bus.key_ready;

    // Next round key from the current one: SubWord(RotWord(w3)) ^ Rcon, then XOR chain.
    assign w_rot     = {r_key[3][23:0], r_key[3][31:24]};
    assign w_temp    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                        sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {r_rcon, 24'h000000};
    assign w_next[0] = r_key[0] ^ w_temp;
    assign w_next[1] = r_key[1] ^ w_next[0];
    assign w_next[2] = r_key[2] ^ w_next[1];
    assign w_next[3] = r_key[3] ^ w_next[2];

    // Control FSM and round-key registers; start is only seen in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= EXPAND;
                        r_key   <= bus.cipher_key;
                        r_round <= '0;
                        r_rcon  <= 8'h01;
                    end
                end
                EXPAND: begin
                    if (w_hs) begin
                        if (r_round == LAST_ROUND) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_key   <= '0;
                            r_round <= '0;
                            r_rcon  <= '0;
                        end else begin
                            r_key   <= w_next;
                            r_round <= r_round + ROUND_W'(1);
                            r_rcon  <= xtime(r_rcon);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.round_key = r_key;
    assign bus.round_num = r_round;
    assign bus.key_valid = (r_state == EXPAND);
    assign bus.busy      = (r_state == EXPAND);
    assign bus.done      = r_done;

`ifdef KEY_STORE_EN
    localparam int unsigned NUM_KEYS = 11;

    logic [0:3][31:0] r_store [0:NUM_KEYS-1];
    logic [0:3][31:0] r_rd_key;

    // Capture each key as it is presented; readback is registered one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_store[i] <= '0;
            end
            r_rd_key <= '0;
        end else begin
            if ((r_state == IDLE) && bus.start) begin
                r_store[0] <= bus.cipher_key;
            end else if (w_hs && (r_round != LAST_ROUND)) begin
                r_store[r_round + ROUND_W'(1)] <= w_next;
            end
            r_rd_key <= (bus.rd_idx <= LAST_ROUND) ? r_store[bus.rd_idx] : '0;
        end
    end

    assign bus.rd_key = r_rd_key;
`else
    logic w_unused_rd_idx;

    assign w_unused_rd_idx = ^bus.rd_idx;
    assign bus.rd_key      = '0;
`endif

endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: FIPS-197 vector, backpressure,
// start handling, mid-run reset and randomized keys/ready patterns against
// a word-array key-expansion model with an algebraically derived S-box.
module tb_key_schedule;
    logic clk;
    logic rst;

    key_schedule_if bus();

    key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]   sb       [0:255];
    logic [7:0]   rcon_tab [0:9];
    logic [127:0] exp_keys [0:10];
    logic [127:0] obs      [0:10];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
        rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
        rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;
    endtask

    // Textbook 44-word expansion, grouped into 11 round keys.
    task automatic build_ref(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts an expansion (called #1 after an edge) and checks every cycle up to done.
    task automatic run_key(input logic [127:0] key, input int ready_pct, input int stall_at,
                           input int stall_len, input int poke_at, output int lat);
        int r;
        int stalls;
        int cyc;
        bit rdy;
        bit finished;
        build_ref(key);
        bus.start      = 1'b1;
        bus.cipher_key = key;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.cipher_key = rand128();
        check("r0_valid", 128'(bus.key_valid), 128'(1));
        check("r0_num", 128'(bus.round_num), 128'(0));
        check("r0_key", bus.round_key, exp_keys[0]);
        obs[0]   = bus.round_key;
        r        = 0;
        stalls   = 0;
        cyc      = 0;
        lat      = -1;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            if (r == stall_at && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(99) < 32'(ready_pct));
            end
            bus.key_ready = rdy;
            if (r == poke_at) begin
                bus.start      = 1'b1;
                bus.cipher_key = rand128();
            end
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (rdy) r++;
            if (r == 11) begin
                check("done_pulse", 128'(bus.done), 128'(1));
                check("end_valid", 128'(bus.key_valid), 128'(0));
                check("end_busy", 128'(bus.busy), 128'(0));
                lat      = cyc;
                finished = 1'b1;
            end else begin
                check("valid", 128'(bus.key_valid), 128'(1));
                check("busy", 128'(bus.busy), 128'(1));
                check("round_num", 128'(bus.round_num), 128'(r));
                check("round_key", bus.round_key, exp_keys[r]);
                obs[r] = bus.round_key;
            end
        end
        bus.key_ready = 1'b0;
        if (!finished) check("timeout", 128'(0), 128'(1));
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_key"}, bus.round_key, 128'(0));
        check({tag, "_num"}, 128'(bus.round_num), 128'(0));
        check({tag, "_valid"}, 128'(bus.key_valid), 128'(0));
        check({tag, "_busy"}, 128'(bus.busy), 128'(0));
        check({tag, "_done"}, 128'(bus.done), 128'(0));
        check({tag, "_rdkey"}, bus.rd_key, 128'(0));
    endtask

    initial begin
        int lat;
        logic [127:0] k;
        logic [127:0] exp_rd;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.key_ready  = 1'b0;
        bus.cipher_key = '0;
        bus.rd_idx     = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;

        // Start while in reset is ignored.
        bus.start      = 1'b1;
        bus.cipher_key = FIPS_KEY;
        @(posedge clk); #1;
        check_idle_zero("reset");
        bus.start = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 128'(bus.key_valid), 128'(0));

        // Full-rate FIPS-197 vector.
        run_key(FIPS_KEY, 100, -1, 0, -1, lat);
        check("fips_latency", 128'(lat), 128'(11));
        check("fips_r1", obs[1], FIPS_R1);
        check("fips_r10", obs[10], FIPS_R10);
        @(posedge clk); #1;
        check("done_one_cycle", 128'(bus.done), 128'(0));

        // Stored-key readback.
        bus.rd_idx = 4'd10;
        @(posedge clk); #1;
`ifdef KEY_STORE_EN
        exp_rd = FIPS_R10;
`else
        exp_rd = '0;
`endif
        check("rd_idx10", bus.rd_key, exp_rd);
        bus.rd_idx = 4'd12;
        @(posedge clk); #1;
        check("rd_idx12", bus.rd_key, 128'(0));
        for (int i = 0; i < 4; i++) begin
            bus.rd_idx = 4'($urandom_range(10));
            @(posedge clk); #1;
`ifdef KEY_STORE_EN
            exp_rd = exp_keys[bus.rd_idx];
`else
            exp_rd = '0;
`endif
            check("rd_rand", bus.rd_key, exp_rd);
        end

        // Backpressure: 3 stall cycles at round 4.
        run_key(FIPS_KEY, 100, 4, 3, -1, lat);
        check("stall_latency", 128'(lat), 128'(14));
        check("stall_r1", obs[1], FIPS_R1);
        check("stall_r10", obs[10], FIPS_R10);

        // Start pulsed mid-expansion, then a new start in the done cycle.
        run_key(FIPS_KEY, 100, -1, 0, 3, lat);
        check("poke_latency", 128'(lat), 128'(11));
        check("poke_r10", obs[10], FIPS_R10);
        check("chain_done", 128'(bus.done), 128'(1));
        run_key(rand128(), 100, -1, 0, -1, lat);
        check("chain_latency", 128'(lat), 128'(11));

        // Reset asserted at round 6.
        k = rand128();
        build_ref(k);
        bus.start      = 1'b1;
        bus.cipher_key = k;
        bus.key_ready  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 20 && bus.round_num != 4'd6; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_num", 128'(bus.round_num), 128'(6));
        check("pre_rst_key", bus.round_key, exp_keys[6]);
        rst = 1'b1;
        #1;
        check_idle_zero("midrst");
        bus.key_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_key(rand128(), 100, -1, 0, -1, lat);
        check("after_rst_latency", 128'(lat), 128'(11));

        // Randomized keys and ready patterns.
        for (int n = 0; n < 6; n++) begin
            run_key(rand128(), int'($urandom_range(40, 95)), int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 4)), -1, lat);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
